// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner: channel FSM states,
// default debounce/repeat tick counts at 100 MHz, and board channel indices.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam int DEBOUNCE_10MS = 1000000;
   localparam int REPEAT_500MS  = 50000000;
   localparam int REPEAT_100MS  = 10000000;

   localparam int BTN_L = 0;
   localparam int BTN_C = 1;
   localparam int BTN_R = 2;

   // Keeps vectors at least one bit wide when a count degenerates to 1.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, debounce FSM, registered press pulse DEBOUNCE_TICKS+3 edges after a raw step.
// No backpressure; BTN_AUTOREPEAT_EN adds held-button repeat pulses.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEBOUNCE_10MS,
   parameter int REPEAT_DELAY   = REPEAT_500MS,
   parameter int REPEAT_PERIOD  = REPEAT_100MS
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_pulse
);

   localparam int            CW       = clog2_min1(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic [1:0]    r_sync;
   logic          w_s;
   btn_state_e    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_level, w_level_nxt;
   logic          r_pulse, w_pulse_nxt;
   logic          w_press;
   logic          w_rpt_hit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], i_raw};
      end
   end

   assign w_s = r_sync[1];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_press     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_s) w_state_nxt = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!w_s) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = HELD;
               w_level_nxt = 1'b1;
               w_press     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         HELD: begin
            if (!w_s) w_state_nxt = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (w_s) begin
               w_state_nxt = HELD;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE;
               w_level_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_state_nxt != r_state) w_cnt_nxt = '0;
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int            RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW       = clog2_min1(RPT_MAX);
   localparam logic [RW-1:0] RPT_DLY  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_PER  = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] r_rpt;
   logic          r_rpt_armed;

   // Counter only advances while settled in HELD; any excursion restarts the initial delay.
   assign w_rpt_hit = (r_state == HELD) && w_s &&
                      (r_rpt == (r_rpt_armed ? RPT_PER : RPT_DLY));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rpt       <= '0;
         r_rpt_armed <= 1'b0;
      end else if ((r_state != HELD) || !w_s) begin
         r_rpt       <= '0;
         r_rpt_armed <= 1'b0;
      end else if (w_rpt_hit) begin
         r_rpt       <= '0;
         r_rpt_armed <= 1'b1;
      end else begin
         r_rpt <= r_rpt + RW'(1);
      end
   end
`else
   assign w_rpt_hit = 1'b0;
`endif

   assign w_pulse_nxt = w_press | w_rpt_hit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   assign o_level = r_level;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_pulse_conditioner.sv
// N_BTN debounced button channels plus any/lowest-index/chord decode of their registered pulses.
// Pulse DEBOUNCE_TICKS+3 edges after a clean raw step; no backpressure; BTN_AUTOREPEAT_EN enables auto-repeat.
module btn_pulse_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN          = 3,
   parameter int DEBOUNCE_TICKS = DEBOUNCE_10MS,
   parameter int REPEAT_DELAY   = REPEAT_500MS,
   parameter int REPEAT_PERIOD  = REPEAT_100MS
) (
   input  logic                            CLOCK,
   input  logic                            RESET_N,
   input  logic [N_BTN-1:0]                btn_raw,
   output logic [N_BTN-1:0]                btn_level,
   output logic [N_BTN-1:0]                btn_pulse,
   output logic                            any_pulse,
   output logic [clog2_min1(N_BTN)-1:0]    event_idx,
   output logic                            chord
);

   localparam int IDX_W = clog2_min1(N_BTN);

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .i_clk   (CLOCK),
         .i_rst_n (RESET_N),
         .i_raw   (btn_raw[g]),
         .o_level (btn_level[g]),
         .o_pulse (btn_pulse[g])
      );
   end

   assign any_pulse = |btn_pulse;

   // Scan downwards so the lowest pulsing index is written last.
   always_comb begin
      event_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (btn_pulse[i]) event_idx = IDX_W'(i);
      end
   end

   // Clearing the lowest set bit leaves something only when two or more were set.
   assign chord = |(btn_pulse & (btn_pulse - N_BTN'(1)));

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Bench for btn_pulse_conditioner: directed scenarios plus random bouncing, compared each cycle
// against a run-length debounce model.
module tb_btn_pulse_conditioner;
   import btn_pkg::*;

   localparam int N   = 3;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;
   localparam int IW  = 2;
   localparam int VW  = 2 * N + 1 + IW + 1;

`ifdef BTN_AUTOREPEAT_EN
   localparam int EXP_CLEAN  = 2;
   localparam int EXP_HOLD40 = 6;
`else
   localparam int EXP_CLEAN  = 1;
   localparam int EXP_HOLD40 = 1;
`endif

   logic          CLOCK   = 1'b0;
   logic          RESET_N = 1'b0;
   logic [N-1:0]  btn_raw = '0;
   logic [N-1:0]  btn_level, btn_pulse;
   logic          any_pulse, chord;
   logic [IW-1:0] event_idx;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK = ~CLOCK;

   btn_pulse_conditioner #(
      .N_BTN          (N),
      .DEBOUNCE_TICKS (DEB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET_N   (RESET_N),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse),
      .any_pulse (any_pulse),
      .event_idx (event_idx),
      .chord     (chord)
   );

   logic [VW-1:0] obs_vec;
   assign obs_vec = {btn_level, btn_pulse, any_pulse, event_idx, chord};

   // Reference: raw reaches the debouncer two edges late; the level flips once the
   // synchronised input has disagreed with it on DEB+1 consecutive edges.
   logic [N-1:0] m_d1, m_d2, m_s, m_level, m_pulse;
   int           m_mism [N];
   int           m_rpt  [N];
   bit           m_first[N];

   always @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         m_d1 = '0; m_d2 = '0; m_level = '0; m_pulse = '0;
         for (int c = 0; c < N; c++) begin
            m_mism[c] = 0; m_rpt[c] = 0; m_first[c] = 1'b1;
         end
      end else begin
         m_s     = m_d2;
         m_d2    = m_d1;
         m_d1    = btn_raw;
         m_pulse = '0;
         for (int c = 0; c < N; c++) begin
            if (m_s[c] != m_level[c]) begin
               m_mism[c]++;
               m_rpt[c]   = 0;
               m_first[c] = 1'b1;
               if (m_mism[c] == DEB + 1) begin
                  m_level[c] = m_s[c];
                  m_pulse[c] = m_s[c];
                  m_mism[c]  = 0;
               end
            end else begin
`ifdef BTN_AUTOREPEAT_EN
               if (m_level[c] && m_mism[c] == 0) begin
                  m_rpt[c]++;
                  if (m_rpt[c] == (m_first[c] ? RD : RP)) begin
                     m_pulse[c] = 1'b1;
                     m_rpt[c]   = 0;
                     m_first[c] = 1'b0;
                  end
               end
`endif
               m_mism[c] = 0;
            end
         end
      end
   end

   function automatic logic [VW-1:0] exp_vec();
      int idx;
      idx = 0;
      for (int i = N - 1; i >= 0; i--) if (m_pulse[i]) idx = i;
      return {m_level, m_pulse, |m_pulse, IW'(idx), ($countones(m_pulse) >= 2)};
   endfunction

   task automatic idle_gap(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   task automatic test_reset();
      btn_raw = 3'b101;
      repeat (3) @(negedge CLOCK);
      checks++;
      if (obs_vec !== '0) begin
         errors++;
         $display("FAIL reset_hold got %b want %b", obs_vec, {VW{1'b0}});
      end
      btn_raw = '0;
      RESET_N = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== '0) begin
            errors++;
            $display("FAIL reset_idle e=%0d got %b want %b", e, obs_vec, {VW{1'b0}});
         end
      end
   endtask

   task automatic test_clean_press();
      int np, pe, fe;
      np = 0; pe = -1; fe = -1;
      btn_raw[BTN_L] = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL clean_press e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (btn_pulse[BTN_L]) begin
            np++;
            if (pe < 0) pe = e;
         end
         if (e == 7) begin
            checks++;
            if ({btn_pulse, event_idx, chord} !== {3'b001, 2'd0, 1'b0}) begin
               errors++;
               $display("FAIL clean_decode got %b want %b", {btn_pulse, event_idx, chord}, 6'b001000);
            end
         end
      end
      checks++;
      if (np !== EXP_CLEAN) begin errors++; $display("FAIL clean_count got %0d want %0d", np, EXP_CLEAN); end
      checks++;
      if (pe !== 7) begin errors++; $display("FAIL clean_latency got %0d want 7", pe); end
      checks++;
      if (btn_level[BTN_L] !== 1'b1) begin errors++; $display("FAIL clean_level got %b want 1", btn_level[BTN_L]); end
      btn_raw[BTN_L] = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL clean_release e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (fe < 0 && btn_level[BTN_L] === 1'b0) fe = e;
      end
      checks++;
      if (fe !== 7) begin errors++; $display("FAIL release_latency got %0d want 7", fe); end
   endtask

   task automatic test_bounce();
      logic [15:0] pat;
      int np, hi;
      pat = 16'b0000_0000_0011_0111;
      np = 0; hi = 0;
      for (int e = 0; e < 16; e++) begin
         btn_raw[BTN_C] = pat[e];
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL bounce e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (btn_pulse[BTN_C]) np++;
         if (btn_level[BTN_C]) hi++;
      end
      checks++;
      if (np !== 0 || hi !== 0) begin errors++; $display("FAIL bounce_reject pulses %0d level_hi %0d want 0 0", np, hi); end
      np = 0;
      btn_raw[BTN_C] = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL bounce_hold e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (btn_pulse[BTN_C]) np++;
      end
      checks++;
      if (np !== 1) begin errors++; $display("FAIL bounce_hold_count got %0d want 1", np); end
      btn_raw[BTN_C] = 1'b0;
      idle_gap(12);
   endtask

   task automatic test_release_bounce();
      int np, lo, fe;
      np = 0; lo = 0; fe = -1;
      btn_raw[BTN_L] = 1'b1;
      idle_gap(9);
      for (int e = 1; e <= 10; e++) begin
         btn_raw[BTN_L] = (e > 2);
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL rel_bounce e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (btn_pulse[BTN_L]) np++;
         if (!btn_level[BTN_L]) lo++;
      end
      checks++;
      if (np !== 0 || lo !== 0) begin errors++; $display("FAIL rel_bounce_hold pulses %0d level_lo %0d want 0 0", np, lo); end
      btn_raw[BTN_L] = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL rel_drop e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (fe < 0 && btn_level[BTN_L] === 1'b0) fe = e;
      end
      checks++;
      if (fe !== 7) begin errors++; $display("FAIL rel_drop_latency got %0d want 7", fe); end
      idle_gap(4);
   endtask

   task automatic test_chord();
      int nc;
      nc = 0;
      btn_raw = 3'b110;
      for (int e = 1; e <= 12; e++) begin
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL chord e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (chord) nc++;
         if (e == 7) begin
            checks++;
            if ({btn_pulse, any_pulse, chord, event_idx} !== {3'b110, 1'b1, 1'b1, 2'd1}) begin
               errors++;
               $display("FAIL chord_decode got %b want %b", {btn_pulse, any_pulse, chord, event_idx}, 7'b1101101);
            end
         end
      end
      checks++;
      if (nc !== 1) begin errors++; $display("FAIL chord_count got %0d want 1", nc); end
      btn_raw = '0;
      idle_gap(12);
   endtask

   task automatic test_reset_mid();
      int np, pe;
      np = 0; pe = -1;
      btn_raw[BTN_R] = 1'b1;
      idle_gap(10);
      btn_raw[BTN_L] = 1'b1;
      idle_gap(4);
      #2 RESET_N = 1'b0;
      #1;
      checks++;
      if (obs_vec !== '0) begin
         errors++;
         $display("FAIL reset_async got %b want %b", obs_vec, {VW{1'b0}});
      end
      @(negedge CLOCK);
      RESET_N = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (btn_pulse[BTN_L]) begin
            np++;
            if (pe < 0) pe = e;
         end
      end
      checks++;
      if (np !== 1 || pe !== 7) begin
         errors++;
         $display("FAIL reset_repress count %0d edge %0d want 1 7", np, pe);
      end
      btn_raw = '0;
      idle_gap(12);
   endtask

   task automatic test_autorepeat();
      int np;
      np = 0;
      btn_raw[BTN_L] = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL hold40 e=%0d got %b want %b", e, obs_vec, exp_vec());
         end
         if (btn_pulse[BTN_L]) np++;
      end
      checks++;
      if (np !== EXP_HOLD40) begin errors++; $display("FAIL hold40_count got %0d want %0d", np, EXP_HOLD40); end
      btn_raw = '0;
      idle_gap(12);
   endtask

   task automatic test_random();
      int run[N];
      for (int c = 0; c < N; c++) run[c] = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int c = 0; c < N; c++) begin
            if (run[c] == 0) begin
               btn_raw[c] = ~btn_raw[c];
               run[c]     = $urandom_range(1, 10);
            end
            run[c]--;
         end
         if (cyc == 700) RESET_N = 1'b0;
         if (cyc == 703) RESET_N = 1'b1;
         @(negedge CLOCK);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random c=%0d got %b want %b", cyc, obs_vec, exp_vec());
         end
      end
      btn_raw = '0;
      idle_gap(12);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_press();
      idle_gap(4);
      test_bounce();
      test_release_bounce();
      test_chord();
      test_reset_mid();
      test_autorepeat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
